// File: rtl/parallel2serial.sv
// Parallel-to-serial transmitter: valid/ready word input, MSB-first serial output,
// idle-word fill between user words. Define P2S_PARITY_EN to append an even-parity bit per frame.
module parallel2serial #(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     IDLE_WORD = 8'hBC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             dout,
  output logic             frame_start,
  output logic             sending_data
);

`ifdef P2S_PARITY_EN
  localparam int unsigned LAST = WIDTH;
`else
  localparam int unsigned LAST = WIDTH - 1;
`endif
  localparam int unsigned    CW     = $clog2(LAST + 1);
  localparam logic [CW-1:0]  LAST_C = CW'(LAST);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_DATA = 1'b1;

  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             state;
  logic             boundary;
  logic [WIDTH-1:0] word;
  logic             fill;

  assign ready_out    = !hold_full;
  assign sending_data = (state == ST_DATA);
  assign boundary     = (cnt == LAST_C);
  assign word         = hold_full ? hold : IDLE_WORD;

  // The bit shifted into sr's LSB emerges right after the word's LSB,
  // so parking the parity bit there makes it the frame's trailing bit.
`ifdef P2S_PARITY_EN
  assign fill = ^word;
`else
  assign fill = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold        <= '0;
      hold_full   <= 1'b0;
      sr          <= '0;
      cnt         <= LAST_C;
      state       <= ST_IDLE;
      dout        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (valid_in && ready_out) begin
        hold      <= data_in;
        hold_full <= 1'b1;
      end
      if (boundary) begin
        if (hold_full) begin
          hold_full <= 1'b0;
          state     <= ST_DATA;
        end else begin
          state     <= ST_IDLE;
        end
        dout        <= word[WIDTH-1];
        sr          <= {word[WIDTH-2:0], fill};
        cnt         <= '0;
        frame_start <= 1'b1;
      end else begin
        dout        <= sr[WIDTH-1];
        sr          <= {sr[WIDTH-2:0], 1'b0};
        cnt         <= cnt + CW'(1);
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_parallel2serial.sv
// Scoreboard bench for parallel2serial: stimulus queues accepted words, a negedge monitor
// reassembles frames and checks them (build with P2S_PARITY_EN for the parity variant).
module tb_parallel2serial;

  localparam int WIDTH = 8;
`ifdef P2S_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int LAST = FL - 1;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;
  logic             dout;
  logic             frame_start;
  logic             sending_data;

  parallel2serial #(.WIDTH(WIDTH), .IDLE_WORD(8'hBC)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .dout(dout), .frame_start(frame_start),
    .sending_data(sending_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int user_frames = 0;
  int idle_frames = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: rebuild each frame from dout and compare against the scoreboard.
  int          bitpos = 0;
  bit          in_frame = 0;
  logic        sd = 1'b0;
  logic [15:0] shreg = '0;
  always @(negedge clk) begin
    logic [WIDTH-1:0] w;
    if (!reset) begin
      in_frame = 0;
    end else begin
      if (in_frame) check("frame_start_period", frame_start, bitpos == FL);
      if (frame_start) begin
        in_frame = 1; bitpos = 0; shreg = '0; sd = sending_data;
      end
      if (in_frame) begin
        check("sending_data_stable", sending_data, sd);
        shreg = {shreg[14:0], dout};
        bitpos++;
        if (bitpos == FL) begin
          w = shreg[FL-1 -: WIDTH];
`ifdef P2S_PARITY_EN
          check("parity_bit", shreg[0], ^w);
`endif
          if (sd) begin
            user_frames++;
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_user_word: got %0h expected none at %0t", w, $time);
            end else begin
              check("user_word", w, exp_q.pop_front());
            end
          end else begin
            idle_frames++;
            check("idle_word", w, 8'hBC);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sync_frame();
    int n = 0;
    do begin tick(); n++; end while (!frame_start && n < 40);
    check("sync_frame_timeout", frame_start, 1'b1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready_out && n < 40) begin tick(); n++; end
    check("wait_ready_timeout", ready_out, 1'b1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin tick(); n++; end
    check("drain_timeout", exp_q.size(), 0);
    tick();
  endtask

  logic [WIDTH-1:0] b2b [3] = '{8'h01, 8'h80, 8'hFF};

  initial begin
    int n, acc_cnt, idle_snap, user_snap;
    bit acc;
    reset = 1'b0; valid_in = 1'b0; data_in = '0;

    // Reset state
    repeat (15) @(posedge clk);
    #1;
    check("rst_dout", dout, 1'b0);
    check("rst_ready", ready_out, 1'b1);
    check("rst_frame_start", frame_start, 1'b0);
    check("rst_sending", sending_data, 1'b0);
    #2 reset = 1'b1;
    tick();
    check("first_edge_boundary", frame_start, 1'b1);
    check("first_bit_idle_msb", dout, 1'b1);
    repeat (3 * FL) tick();

    // Single word accepted at cnt=3 of an idle word
    sync_frame();
    repeat (3) tick();
    valid_in = 1'b1; data_in = 8'hA5;
    @(posedge clk); exp_q.push_back(8'hA5); #1;
    valid_in = 1'b0; data_in = 8'h00;
    check("ready_low_after_accept", ready_out, 1'b0);
    n = 0;
    do begin tick(); n++; end while (!frame_start && n < 20);
    check("latency_cnt3", n, LAST - 3);
    check("sending_on_first_bit", sending_data, 1'b1);
    check("ready_after_boundary", ready_out, 1'b1);
    wait_drain();
    repeat (2 * FL) tick();

    // Parity-check word
    wait_ready();
    valid_in = 1'b1; data_in = 8'h07;
    @(posedge clk); exp_q.push_back(8'h07); #1;
    valid_in = 1'b0;
    wait_drain();

    // Back-to-back with valid held high
    sync_frame();
    valid_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = b2b[i];
      wait_ready();
      @(posedge clk); exp_q.push_back(b2b[i]); #1;
      check("b2b_ready_low", ready_out, 1'b0);
    end
    valid_in = 1'b0;
    n = 0;
    while (!sending_data && n < 40) begin tick(); n++; end
    idle_snap = idle_frames;
    wait_drain();
    check("b2b_no_idle_gap", idle_frames, idle_snap);

    // Backpressure with toggling data
    sync_frame();
    user_snap = user_frames;
    acc_cnt = 0;
    valid_in = 1'b1;
    for (int k = 0; k < 3 * FL + 3; k++) begin
      data_in = (k % 2 == 0) ? 8'h3C : 8'hC3;
      acc = ready_out;
      @(posedge clk);
      if (acc) begin exp_q.push_back(data_in); acc_cnt++; end
      #1;
    end
    valid_in = 1'b0;
    wait_drain();
    check("bp_accepts_eq_words", user_frames - user_snap, acc_cnt);
    check("bp_accepts_min", acc_cnt >= 3, 1'b1);

    // Mid-word reset with a word in hold
    wait_ready();
    valid_in = 1'b1; data_in = 8'hC3;
    @(posedge clk); exp_q.push_back(8'hC3); #1;
    valid_in = 1'b0;
    n = 0;
    while (!(frame_start && sending_data) && n < 40) begin tick(); n++; end
    check("c3_started", sending_data, 1'b1);
    valid_in = 1'b1; data_in = 8'h5A;
    @(posedge clk); #1;
    valid_in = 1'b0;
    check("hold_loaded", ready_out, 1'b0);
    @(posedge clk);
    exp_q.delete();
    #2 reset = 1'b0;
    #1;
    check("async_rst_dout", dout, 1'b0);
    check("async_rst_frame_start", frame_start, 1'b0);
    check("async_rst_sending", sending_data, 1'b0);
    check("async_rst_ready", ready_out, 1'b1);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    user_snap = user_frames;
    idle_snap = idle_frames;
    repeat (4 * FL + 2) tick();
    check("post_rst_no_user", user_frames, user_snap);
    check("post_rst_idle_frames", idle_frames - idle_snap >= 3, 1'b1);

    check("queue_empty_end", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/parallel2serial.md
# parallel2serial

Parallel-to-serial transmitter. It is the sending end of the serial link that the serial-to-parallel converter receives. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock, MSB first, on a single serial line. When no user word is pending, it keeps the line busy with a fixed idle word, so the receiver always sees a continuous framed bit stream.

## Interface
- WIDTH, 8, bits per word (≥2).
- IDLE_WORD, 8'hBC, word transmitted when no user data is pending (width WIDTH).
- clk  input  1  rising-edge clock, one serial bit per cycle.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- data_in  input  WIDTH  parallel word from upstream.
- valid_in  input  1  data_in holds a word to send.
- ready_out  output  1  holding buffer empty; a word is accepted on any rising edge where valid_in and ready_out are both 1.
- dout  output  1  serial data, registered.
- frame_start  output  1  high during the first bit of every word (user or idle), registered.
- sending_data  output  1  high during every bit of a user word, low during idle words, registered.

## Operation
- Storage:
  - holding buffer hold[WIDTH-1:0] with flag hold_full;
  - shift register sr[WIDTH-1:0];
  - bit counter cnt, range 0..LAST. LAST = WIDTH-1, or WIDTH when parity is enabled.
  - ready_out = !hold_full (combinational from the flag).
- Accept: when valid_in && ready_out at a rising edge, hold <= data_in and hold_full <= 1. There is no bypass into sr.
- Boundary edge: a rising edge where cnt == LAST. The next word is selected as follows.
  - hold_full = 1 → word = hold, hold_full <= 0, sending_data <= 1 (DATA state).
  - hold_full = 0 → word = IDLE_WORD, sending_data <= 0 (IDLE state).
  - On the same edge: dout <= word[WIDTH-1], sr <= {word[WIDTH-2:0], 1'b0}, cnt <= 0, frame_start <= 1.
- Non-boundary edge: dout <= sr[WIDTH-1], sr <= sr << 1, cnt <= cnt + 1, frame_start <= 0. sending_data is held.
- States: IDLE and DATA, re-evaluated only at boundary edges, so a word is never truncated. Transitions:
  - IDLE→DATA and DATA→DATA when hold_full;
  - DATA→IDLE and IDLE→IDLE otherwise.
- Simultaneous accept and boundary: the load uses the pre-edge hold_full. A word accepted on a boundary edge while hold is empty waits for the next boundary. Because ready_out = 0 whenever hold_full = 1, an accept and a load from hold never coincide.
- Upstream may change data_in freely while ready_out = 0. The block samples it only on accept.

## Timing
- Reset values (asynchronous, while reset = 0):
  - dout = 0, frame_start = 0, sending_data = 0, ready_out = 1;
  - hold_full = 0, sr = 0, cnt = LAST.
- The first rising edge after reset release is a boundary edge.
- Word period: LAST+1 cycles. frame_start pulses exactly once per period.
- Latency:
  - An accepted word's MSB appears on dout at the next boundary edge after the accept edge.
  - That takes 1..LAST+1 cycles, or LAST+1 if accepted on a boundary edge.
- Throughput: full line rate. hold frees at each boundary, and upstream has LAST edges to refill it, so a continuously valid source produces back-to-back user words with no idle word between them.
- Reset mid-operation: the partial word in sr and any word in hold are discarded. Neither is transmitted after release.

## Configuration
- P2S_PARITY_EN defined:
  - LAST = WIDTH, so each frame is WIDTH+1 bits.
  - The extra bit, sent after the LSB, is the even-parity bit (XOR of the WIDTH word bits). It is computed at the boundary edge and applies to both idle and user words.
  - sending_data stays high through the parity bit of a user word.
- P2S_PARITY_EN undefined: LAST = WIDTH-1, frames are WIDTH bits, and there is no parity logic.

## Test plan
- Reset/idle: hold reset low 15 cycles → dout = 0, ready_out = 1, frame_start = 0, sending_data = 0. After release with valid_in = 0 → dout repeats 1,0,1,1,1,1,0,0 and frame_start pulses every 8 cycles.
- Single word: accept 8'hA5 at cnt = 3 of an idle word → after that idle word completes, dout = 1,0,1,0,0,1,0,1 with sending_data = 1 for exactly those 8 cycles. Idle words resume afterwards.
- Back-to-back: valid_in held high with 8'h01, 8'h80, 8'hFF presented one per accept → 24 contiguous data bits with sending_data continuously 1. ready_out is low from each accept edge until the next boundary.
- Backpressure: valid_in high while ready_out = 0, with data_in toggling between 8'h3C and 8'hC3 → only the value present at each accept edge is transmitted. The number of accepts equals the number of user words out.
- Mid-word reset: pull reset low after 3 bits of 8'hC3 with 8'h5A in hold → outputs take reset values immediately without a clock edge. After release, only idle words appear.
- Parity build (P2S_PARITY_EN): accept 8'h07 → 0,0,0,0,0,1,1,1,1. Idle frames → 1,0,1,1,1,1,0,0,1 and frame_start every 9 cycles.
